// File: rtl/accum_bank_pkg.sv
// Shared opcode encodings and control FSM states for the accumulator bank.
package accum_bank_pkg;

    localparam logic [1:0] OP_ADD       = 2'd0;
    localparam logic [1:0] OP_LOAD      = 2'd1;
    localparam logic [1:0] OP_CLEAR     = 2'd2;
    localparam logic [1:0] OP_CLEAR_ALL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2
    } state_e;

endpackage

// File: rtl/accum_alu.sv
// Unsigned accumulate with carry detect; result clamps to all-ones on carry when sat_i is set.
// Purely combinational, no backpressure.
module accum_alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    logic [WIDTH:0] sum;

    assign sum      = {1'b0, acc_i} + {1'b0, value_i};
    assign carry_o  = sum[WIDTH];
    assign result_o = (sum[WIDTH] && sat_i) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

endmodule

// File: rtl/accum_bank.sv
// Multi-channel accumulator bank: ADD/LOAD/CLEAR via a 2-stage pipe, CLEAR_ALL via a drain+sweep FSM.
// Result 3 edges after accept; ready drops only while a CLEAR_ALL drains and sweeps.
module accum_bank
    import accum_bank_pkg::*;
#(
    parameter int  WIDTH    = 16,
    parameter int  CHANNELS = 4,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                io_cmd_valid,
    output logic                io_cmd_ready,
    input  logic [1:0]          io_cmd_op,
    input  logic [CW-1:0]       io_cmd_chan,
    input  logic [WIDTH-1:0]    io_cmd_value,
    input  logic                io_cmd_sat,
    output logic                io_sum_valid,
    output logic [CW-1:0]       io_sum_chan,
    output logic [WIDTH-1:0]    io_sum_data,
    input  logic [CW-1:0]       io_rd_chan,
    output logic [WIDTH-1:0]    io_rd_data,
    output logic [CHANNELS-1:0] io_ovf,
    output logic                io_busy
);

    state_e              state_q, state_d;
    logic [CW-1:0]       sw_idx_q, sw_idx_d;

    logic                s1_vld_q, s1_vld_d;
    logic [1:0]          s1_op_q, s1_op_d;
    logic [CW-1:0]       s1_chan_q, s1_chan_d;
    logic [WIDTH-1:0]    s1_val_q, s1_val_d;
    logic                s1_sat_q, s1_sat_d;

    logic                s2_vld_q, s2_vld_d;
    logic [1:0]          s2_op_q, s2_op_d;
    logic [CW-1:0]       s2_chan_q, s2_chan_d;
    logic [WIDTH-1:0]    s2_val_q, s2_val_d;
    logic                s2_sat_q, s2_sat_d;
    logic [WIDTH-1:0]    s2_acc_q, s2_acc_d;

    logic [WIDTH-1:0]    acc_q [CHANNELS];
    logic [WIDTH-1:0]    acc_d [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;

    logic                sum_vld_q, sum_vld_d;
    logic [CW-1:0]       sum_chan_q, sum_chan_d;
    logic [WIDTH-1:0]    sum_dat_q, sum_dat_d;
    logic [WIDTH-1:0]    rd_dat_q, rd_dat_d;

    logic                cmd_fire;
    logic [WIDTH-1:0]    add_res;
    logic                add_carry;
    logic [WIDTH-1:0]    s2_res;

    assign io_cmd_ready = (state_q == IDLE);
    assign io_busy      = (state_q != IDLE);
    assign cmd_fire     = io_cmd_valid && io_cmd_ready;

    accum_alu #(.WIDTH(WIDTH)) u_alu (
        .acc_i    (s2_acc_q),
        .value_i  (s2_val_q),
        .sat_i    (s2_sat_q),
        .result_o (add_res),
        .carry_o  (add_carry)
    );

    always_comb begin
        s2_res = '0;
        case (s2_op_q)
            OP_ADD:  s2_res = add_res;
            OP_LOAD: s2_res = s2_val_q;
            default: s2_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sw_idx_d   = sw_idx_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;

        // CLEAR_ALL never enters the pipe; the FSM owns it.
        s1_vld_d   = cmd_fire && (io_cmd_op != OP_CLEAR_ALL);
        s1_op_d    = cmd_fire ? io_cmd_op    : s1_op_q;
        s1_chan_d  = cmd_fire ? io_cmd_chan  : s1_chan_q;
        s1_val_d   = cmd_fire ? io_cmd_value : s1_val_q;
        s1_sat_d   = cmd_fire ? io_cmd_sat   : s1_sat_q;

        s2_vld_d   = s1_vld_q;
        s2_op_d    = s1_op_q;
        s2_chan_d  = s1_chan_q;
        s2_val_d   = s1_val_q;
        s2_sat_d   = s1_sat_q;
        // Operand is captured on the same edge S2 writes, so take the in-flight result.
        s2_acc_d   = (s2_vld_q && (s2_chan_q == s1_chan_q)) ? s2_res : acc_q[s1_chan_q];

        sum_vld_d  = s2_vld_q;
        sum_chan_d = s2_vld_q ? s2_chan_q : sum_chan_q;
        sum_dat_d  = s2_vld_q ? s2_res    : sum_dat_q;
        rd_dat_d   = acc_q[io_rd_chan];

        if (s2_vld_q) begin
            acc_d[s2_chan_q] = s2_res;
            if (s2_op_q == OP_ADD && add_carry) begin
                ovf_d[s2_chan_q] = 1'b1;
            end else if (s2_op_q == OP_CLEAR) begin
                ovf_d[s2_chan_q] = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (cmd_fire && io_cmd_op == OP_CLEAR_ALL) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d  = SWEEP;
                    sw_idx_d = '0;
                end
            end
            SWEEP: begin
                acc_d[sw_idx_q] = '0;
                ovf_d[sw_idx_q] = 1'b0;
                sw_idx_d        = sw_idx_q + 1'b1;
                if (sw_idx_q == CW'(CHANNELS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sw_idx_q   <= '0;
            s1_vld_q   <= 1'b0;
            s1_op_q    <= '0;
            s1_chan_q  <= '0;
            s1_val_q   <= '0;
            s1_sat_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_op_q    <= '0;
            s2_chan_q  <= '0;
            s2_val_q   <= '0;
            s2_sat_q   <= 1'b0;
            s2_acc_q   <= '0;
            acc_q      <= '{default: '0};
            ovf_q      <= '0;
            sum_vld_q  <= 1'b0;
            sum_chan_q <= '0;
            sum_dat_q  <= '0;
            rd_dat_q   <= '0;
        end else begin
            state_q    <= state_d;
            sw_idx_q   <= sw_idx_d;
            s1_vld_q   <= s1_vld_d;
            s1_op_q    <= s1_op_d;
            s1_chan_q  <= s1_chan_d;
            s1_val_q   <= s1_val_d;
            s1_sat_q   <= s1_sat_d;
            s2_vld_q   <= s2_vld_d;
            s2_op_q    <= s2_op_d;
            s2_chan_q  <= s2_chan_d;
            s2_val_q   <= s2_val_d;
            s2_sat_q   <= s2_sat_d;
            s2_acc_q   <= s2_acc_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            sum_vld_q  <= sum_vld_d;
            sum_chan_q <= sum_chan_d;
            sum_dat_q  <= sum_dat_d;
            rd_dat_q   <= rd_dat_d;
        end
    end

    assign io_sum_valid = sum_vld_q;
    assign io_sum_chan  = sum_chan_q;
    assign io_sum_data  = sum_dat_q;
    assign io_rd_data   = rd_dat_q;
    assign io_ovf       = ovf_q;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (sum_vld_q) begin
            $display("accum_bank: sum chan=%0d data=0x%0h", sum_chan_q, sum_dat_q);
        end
    end
`endif

endmodule
